accum_frame_driver: RTL and testbench

Upstream framer for the complex accumulator. It accepts a valid/ready stream of `complex_t` products with a per-frame `in_last` marker and buffers each frame whole (store-and-forward). It then replays every frame as a gap-free burst with `start`/`stop` framing that meets the accumulator's input contract. Frames shorter than the accumulator minimum are zero-padded; over-long frames are truncated and flagged.

---
 rtl/accum_frame_driver_pkg.sv | 29 ++
 rtl/accum_frame_driver_fifo.sv | 54 +++++
 rtl/accum_frame_driver.sv | 151 +++++++++++++++
 tb/tb_accum_frame_driver.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/accum_frame_driver_pkg.sv
// Shared types and constants for the accumulator framer and the accumulator itself.
package accum_frame_driver_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned ACC_MIN_LEN = 12;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } complex_t;

  typedef struct packed {
    complex_t data;
    logic     last;
  } frame_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_PAD,
    ST_GAP
  } drv_state_e;

  // Counter width able to index n distinct values (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/accum_frame_driver_fifo.sv
// Synchronous FIFO of {complex_t, last} entries with show-ahead head and occupancy count.
module complex_frame_fifo
  import accum_frame_driver_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            wr_en,
  input  frame_entry_t                    wr_entry,
  input  logic                            rd_en,
  output frame_entry_t                    head_c,
  output logic                            full_c,
  output logic                            empty_c,
  output logic [cnt_w(DEPTH+1)-1:0]       count
);

  localparam int unsigned AW = cnt_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH + 1);

  frame_entry_t      mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Storage has no reset: pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_c  = mem[rd_ptr];
  assign full_c  = (count == CW'(DEPTH));
  assign empty_c = (count == '0);

endmodule

// File: rtl/accum_frame_driver.sv
// Store-and-forward framer: buffers whole frames and replays them as gap-free start/stop bursts,
// zero-padding short frames to MIN_LEN and truncating frames longer than DEPTH.
module accum_frame_driver
  import accum_frame_driver_pkg::*;
#(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned MIN_LEN = ACC_MIN_LEN,
  parameter int unsigned MIN_GAP = 0
) (
  input  logic     clk,
  input  logic     reset,
  input  complex_t in_data,
  input  logic     in_valid,
  input  logic     in_last,
  output logic     in_ready,
  output complex_t out,
  output logic     out_valid,
  output logic     start,
  output logic     stop,
  output logic     err_trunc,
  input  logic     clr_err
);

  localparam int unsigned CW       = cnt_w(DEPTH + 1);
  localparam int unsigned SW       = cnt_w(DEPTH + MIN_LEN + 1);
  localparam int unsigned GW       = cnt_w(MIN_GAP + 1);
  localparam int unsigned GAP_LAST = (MIN_GAP > 0) ? MIN_GAP - 1 : 0;

  drv_state_e    state, state_d;
  logic [SW-1:0] sent, sent_d, sent_inc;
  logic [GW-1:0] gap_cnt, gap_d;
  logic [CW-1:0] frames;
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_nxt;
  logic          fifo_full_c, fifo_empty_c;
  logic          wr, pop, forced;
  frame_entry_t  wr_entry, head_c;
  complex_t      out_d;
  logic          out_valid_d, start_d, stop_d;

  complex_frame_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr),
    .wr_entry (wr_entry),
    .rd_en    (pop),
    .head_c   (head_c),
    .full_c   (fifo_full_c),
    .empty_c  (fifo_empty_c),
    .count    (fifo_count)
  );

  // Input side: a beat reaching MAX_LEN closes the frame regardless of in_last.
  assign wr             = in_valid && in_ready && !fifo_full_c;
  assign forced         = (beat_cnt == CW'(DEPTH - 1));
  assign wr_entry.data  = in_data;
  assign wr_entry.last  = in_last || forced;
  assign count_nxt      = fifo_count + CW'(wr) - CW'(pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt  <= '0;
      frames    <= '0;
      err_trunc <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      if (wr) beat_cnt <= wr_entry.last ? '0 : beat_cnt + CW'(1);
      if (wr && forced && !in_last) err_trunc <= 1'b1;
      else if (clr_err)             err_trunc <= 1'b0;
      case ({wr && wr_entry.last, pop && head_c.last})
        2'b10:   frames <= frames + CW'(1);
        2'b01:   frames <= frames - CW'(1);
        default: frames <= frames;
      endcase
      in_ready <= (count_nxt != CW'(DEPTH));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      sent      <= '0;
      gap_cnt   <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      start     <= 1'b0;
      stop      <= 1'b0;
    end else begin
      state     <= state_d;
      sent      <= sent_d;
      gap_cnt   <= gap_d;
      out       <= out_d;
      out_valid <= out_valid_d;
      start     <= start_d;
      stop      <= stop_d;
    end
  end

  // Leaving IDLE issues the first pop directly so launch costs only one extra edge.
  always_comb begin
    state_d     = state;
    sent_d      = sent;
    sent_inc    = sent + SW'(1);
    gap_d       = gap_cnt;
    pop         = 1'b0;
    out_d       = '0;
    out_valid_d = 1'b0;
    start_d     = 1'b0;
    stop_d      = 1'b0;
    case (state)
      ST_IDLE, ST_SEND: begin
        if (state == ST_SEND || (frames != '0 && !fifo_empty_c)) begin
          pop         = 1'b1;
          out_d       = head_c.data;
          out_valid_d = 1'b1;
          start_d     = (state == ST_IDLE);
          sent_inc    = (state == ST_IDLE) ? SW'(1) : sent + SW'(1);
          sent_d      = sent_inc;
          state_d     = ST_SEND;
          if (head_c.last) begin
            if (sent_inc >= SW'(MIN_LEN)) begin
              stop_d  = 1'b1;
              sent_d  = '0;
              gap_d   = '0;
              state_d = (MIN_GAP > 0) ? ST_GAP : ST_IDLE;
            end else begin
              state_d = ST_PAD;
            end
          end
        end
      end
      ST_PAD: begin
        out_valid_d = 1'b1;
        sent_d      = sent_inc;
        if (sent_inc >= SW'(MIN_LEN)) begin
          stop_d  = 1'b1;
          sent_d  = '0;
          gap_d   = '0;
          state_d = (MIN_GAP > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GW'(GAP_LAST)) state_d = ST_IDLE;
        else                          gap_d   = gap_cnt + GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_accum_frame_driver.sv
// Directed scoreboard bench for accum_frame_driver (MIN_GAP 0 main instance, MIN_GAP 3 side instance).
module tb_accum_frame_driver;
  import accum_frame_driver_pkg::*;

  typedef struct packed {
    complex_t d;
    logic     start;
    logic     stop;
  } exp_t;

  logic     clk = 1'b0;
  logic     reset;
  complex_t in_data;
  logic     in_valid, in_last, clr_err, gap_en;
  logic     in_ready, out_valid, start, stop, err_trunc;
  complex_t o_data;
  logic     g_ready, g_out_valid, g_start, g_stop, g_err;
  complex_t g_out;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_acc_cyc, start_cyc0, stop_cyc0, g_stop_cyc;
  int   gap0, gapg, n_beats, mc;
  logic have_stop0, g_have, in_frame0, mon_en, saw_full, exp_err;
  exp_t     exp_q[$];
  complex_t cur[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  accum_frame_driver #(.DEPTH(64), .MIN_LEN(12), .MIN_GAP(0)) u_dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out(o_data), .out_valid(out_valid), .start(start), .stop(stop),
    .err_trunc(err_trunc), .clr_err(clr_err)
  );

  accum_frame_driver #(.DEPTH(64), .MIN_LEN(12), .MIN_GAP(3)) u_gap (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid && gap_en), .in_last(in_last),
    .in_ready(g_ready), .out(g_out), .out_valid(g_out_valid), .start(g_start), .stop(g_stop),
    .err_trunc(g_err), .clr_err(clr_err)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic complex_t mk(input int re, input int im);
    complex_t c;
    c.re = re;
    c.im = im;
    return c;
  endfunction

  // Reference framing: truncate at 64, pad to 12, start on first and stop on last emitted beat.
  task automatic model_beat(input complex_t d, input logic last);
    int len;
    exp_t e;
    cur.push_back(d);
    mc++;
    if (last || mc == 64) begin
      if (!last) exp_err = 1'b1;
      len = cur.size();
      for (int i = 0; i < len; i++) begin
        e.d = cur[i]; e.start = (i == 0); e.stop = (i == len - 1) && (len >= 12);
        exp_q.push_back(e);
      end
      for (int i = len; i < 12; i++) begin
        e.d = '0; e.start = 1'b0; e.stop = (i == 11);
        exp_q.push_back(e);
      end
      cur.delete();
      mc = 0;
    end
  endtask

  task automatic send_beat(input complex_t d, input logic last);
    int guard = 0;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    while (!(in_ready && (!gap_en || g_ready)) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("ready_timeout", 128'(guard < 2000), 128'(1));
    @(negedge clk);
    last_acc_cyc = cyc;
    model_beat(d, last);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int len, input int base);
    for (int k = 1; k <= len; k++) send_beat(mk(base + k, -(base + k)), k == len);
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((exp_q.size() != 0 || out_valid || g_out_valid) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", 128'(guard < 3000), 128'(1));
    repeat (6) @(negedge clk);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (!in_ready) saw_full = 1'b1;
        if (in_frame0) check("contiguous", 128'(out_valid), 128'(1));
        if (out_valid) begin
          n_cmp++;
          assert (exp_q.size() != 0) else begin
            n_err++;
            $error("FAIL sb_extra: observed beat %0h expected none", o_data);
          end
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_beat", 128'({o_data, start, stop}), 128'({e.d, e.start, e.stop}));
          end
          n_beats++;
          if (start) begin
            start_cyc0 = cyc;
            if (have_stop0) gap0 = cyc - stop_cyc0;
            in_frame0 = 1'b1;
          end
          if (stop) begin
            stop_cyc0  = cyc;
            have_stop0 = 1'b1;
            in_frame0  = 1'b0;
          end
        end else begin
          check("idle_zero", 128'({o_data, start, stop}), 128'(0));
        end
        if (g_out_valid && g_start && g_have) gapg = cyc - g_stop_cyc;
        if (g_out_valid && g_stop) begin
          g_stop_cyc = cyc;
          g_have     = 1'b1;
        end
      end
    end
  endtask

  initial begin
    int l1, base;
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; clr_err = 1'b0; gap_en = 1'b0;
    mon_en = 1'b0; have_stop0 = 1'b0; g_have = 1'b0; in_frame0 = 1'b0; saw_full = 1'b0;
    exp_err = 1'b0; mc = 0; n_beats = 0; gap0 = -1; gapg = -1; start_cyc0 = 0;
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    check("reset_outs", 128'({in_ready, o_data, out_valid, start, stop, err_trunc}), 128'(0));
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 128'(in_ready), 128'(1));
    mon_en = 1'b1;

    // Exact minimum length frame and launch latency
    send_frame(12, 0);
    l1 = last_acc_cyc;
    wait_drain();
    check("launch_lat", 128'(start_cyc0 - l1), 128'(1));

    // Short frame padded to 12
    send_frame(5, 100);
    wait_drain();
    check("err_short", 128'(err_trunc), 128'(exp_err));

    // Back-to-back frames on both gap settings
    gap_en = 1'b1; gap0 = -1; gapg = -1;
    send_frame(20, 200);
    send_frame(20, 300);
    gap_en = 1'b0;
    wait_drain();
    check("b2b_gap0", 128'(gap0), 128'(1));
    check("b2b_gap3", 128'(gapg), 128'(4));
    check("gap_inst_idle", 128'({g_out, g_out_valid, g_start, g_stop, g_err}), 128'(0));

    // Over-long frame truncated at 64
    send_frame(70, 1000);
    wait_drain();
    check("err_set", 128'(err_trunc), 128'(1));
    check("err_model", 128'(err_trunc), 128'(exp_err));
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    exp_err = 1'b0;
    check("err_clr", 128'(err_trunc), 128'(0));

    // Full FIFO stall with an 80-beat source burst
    saw_full = 1'b0;
    send_frame(80, 2000);
    wait_drain();
    check("saw_full", 128'(saw_full), 128'(1));
    check("err_full", 128'(err_trunc), 128'(exp_err));

    // Reset in the middle of an output burst
    base = n_beats;
    send_frame(30, 3000);
    for (int g = 0; g < 200 && n_beats < base + 7; g++) @(negedge clk);
    check("mid_burst", 128'(out_valid), 128'(1));
    #2 reset = 1'b0;
    mon_en = 1'b0;
    #1 check("rst_mid_outs", 128'({in_ready, o_data, out_valid, start, stop, err_trunc}), 128'(0));
    exp_q.delete(); cur.delete(); mc = 0; exp_err = 1'b0; in_frame0 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hold_outs", 128'({in_ready, o_data, out_valid, start, stop, err_trunc}), 128'(0));
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_rst2", 128'(in_ready), 128'(1));
    mon_en = 1'b1;
    send_frame(12, 4000);
    wait_drain();
    check("err_final", 128'(err_trunc), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
